// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: loader states, word geometry
// and the default load address.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_LEN,
        ST_DATA,
        ST_CHK,
        ST_DONE,
        ST_ERR
    } state_t;

    localparam int          IMEM_WORD_BYTES   = 4;
    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0000_0000;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs a byte stream MSB-first into 32-bit words; word_valid fires combinationally
// on the byte that completes a word, with the full word presented alongside.
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        take,
    input  logic [7:0]  data,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [23:0] shift;
    logic [1:0]  idx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift <= '0;
            idx   <= '0;
        end else if (clear) begin
            shift <= '0;
            idx   <= '0;
        end else if (take) begin
            shift <= {shift[15:0], data};
            idx   <= idx + 2'd1;
        end
    end

    assign word_valid = take && (idx == 2'(IMEM_WORD_BYTES - 1));
    assign word       = {shift, data};

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed big-endian program image into instruction memory and holds
// the CPU in reset until loaded. Define IMEM_LOADER_CHKSUM_EN for an XOR trailer check.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter int          MAX_WORDS = 256,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic             byte_valid_i,
    input  logic [7:0]       byte_data_i,
    output logic             byte_ready_o,
    output logic             wr_en_imem_o,
    output logic [31:0]      wr_addr_imem_o,
    output logic [31:0]      wr_instr_imem_o,
    output logic             cpu_reset_o,
    output logic             done_o,
    output logic             err_o,
    output logic [CNT_W-1:0] words_loaded_o
);

`ifdef IMEM_LOADER_CHKSUM_EN
    localparam state_t POST_DATA = ST_CHK;
`else
    localparam state_t POST_DATA = ST_DONE;
`endif

    state_t      state, state_nx;
    logic        take, pack_take, word_valid, last_word;
    logic [31:0] word, total;

    assign byte_ready_o = (state == ST_LEN) || (state == ST_DATA) || (state == ST_CHK);
    // A byte arriving together with start_i belongs to the abandoned image.
    assign take         = byte_valid_i && byte_ready_o && !start_i;
    assign pack_take    = take && ((state == ST_LEN) || (state == ST_DATA));
    assign last_word    = (32'(words_loaded_o) + 32'd1) == total;
    assign done_o       = (state == ST_DONE);
    assign err_o        = (state == ST_ERR);

    byte_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (start_i),
        .take       (pack_take),
        .data       (byte_data_i),
        .word_valid (word_valid),
        .word       (word)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_LEN;
        else       state <= state_nx;
    end

`ifdef IMEM_LOADER_CHKSUM_EN
    logic [7:0] chksum;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)          chksum <= '0;
        else if (start_i)   chksum <= '0;
        else if (pack_take) chksum <= chksum ^ byte_data_i;
    end
`endif

    always_comb begin
        state_nx = state;
        if (start_i) begin
            state_nx = ST_LEN;
        end else begin
            case (state)
                ST_LEN: begin
                    if (word_valid) begin
                        if (word > 32'(MAX_WORDS)) state_nx = ST_ERR;
                        else if (word == '0)       state_nx = POST_DATA;
                        else                       state_nx = ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (word_valid && last_word) state_nx = POST_DATA;
                end
`ifdef IMEM_LOADER_CHKSUM_EN
                ST_CHK: begin
                    if (take) state_nx = (byte_data_i == chksum) ? ST_DONE : ST_ERR;
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_en_imem_o    <= 1'b0;
            wr_addr_imem_o  <= BASE_ADDR;
            wr_instr_imem_o <= '0;
            words_loaded_o  <= '0;
            total           <= '0;
            cpu_reset_o     <= 1'b1;
        end else if (start_i) begin
            wr_en_imem_o    <= 1'b0;
            wr_addr_imem_o  <= BASE_ADDR;
            wr_instr_imem_o <= '0;
            words_loaded_o  <= '0;
            total           <= '0;
            cpu_reset_o     <= 1'b1;
        end else begin
            wr_en_imem_o <= 1'b0;
            if (state == ST_LEN && word_valid) total <= word;
            if (state == ST_DATA && word_valid) begin
                wr_en_imem_o    <= 1'b1;
                wr_addr_imem_o  <= BASE_ADDR + 32'(words_loaded_o) * 32'(IMEM_WORD_BYTES);
                wr_instr_imem_o <= word;
                words_loaded_o  <= words_loaded_o + 1'b1;
            end
            // Release one cycle after DONE is entered so the final write lands first.
            cpu_reset_o <= (state != ST_DONE);
        end
    end

endmodule
